// File: rtl/bp_pkg.sv
// Shared types for the branch predictor resolve path.
package bp_pkg;

   typedef struct packed {
      logic        taken;
      logic [31:0] target;
      logic [31:0] pc;
   } bp_entry_t;

   localparam logic [31:0] BP_INSN_BYTES = 32'd4;

   // Update pair consumed by the predictor (branch_i / branch_decision).
   typedef struct packed {
      logic valid;
      logic taken;
   } bp_upd_t;

endpackage

// File: rtl/bp_pred_fifo.sv
// In-flight prediction FIFO: wrap-around pointers plus occupancy count, clear wins.
module bp_pred_fifo
   import bp_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = bp_entry_t,
   parameter int  CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  T              data_i,
   output T              head_o,
   output logic [CW-1:0] count_o
);

   localparam int AW = $clog2(DEPTH);

   T              mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q + CW'(push_i) - CW'(pop_i);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !clear_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/branch_resolution_unit.sv
// Resolve side of the 1-bit branch predictor: checks EX outcomes against queued
// predictions, drives predictor updates, flushes on mispredicts, counts events.
module branch_resolution_unit
   import bp_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pred_valid_i,
   input  logic             pred_taken_i,
   input  logic [31:0]      pred_target_i,
   input  logic [31:0]      pred_pc_i,
   output logic             pred_ready_o,
   input  logic             res_valid_i,
   input  logic             res_taken_i,
   input  logic [31:0]      res_target_i,
   output logic             upd_valid_o,
   output logic             upd_taken_o,
   output logic             flush_o,
   output logic [31:0]      redirect_addr_o,
   output logic [CNT_W-1:0] branch_cnt_o,
   output logic [CNT_W-1:0] mispred_cnt_o,
   output logic             underflow_o
);

   localparam int            CW       = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   bp_entry_t     head, wr_entry;
   logic [CW-1:0] count;
   logic          empty, res_hit, mispred, kill, push, pop;

   bp_upd_t          upd_q, upd_d;
   logic             flush_q, flush_d;
   logic [31:0]      redirect_q, redirect_d;
   logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
   logic             underflow_q, underflow_d;

   assign empty    = (count == '0);
   assign res_hit  = res_valid_i && !empty;
   // Not-taken on both sides never mispredicts; the target only matters when taken.
   assign mispred  = res_hit && ((res_taken_i != head.taken) ||
                                 (res_taken_i && (res_target_i != head.target)));
   assign kill     = mispred || flush_q;
   assign pop      = res_hit && !mispred;

   assign pred_ready_o = (count != FULL_CNT) && !flush_q;
   // A full FIFO still takes a push when the head retires correctly the same cycle.
   assign push     = pred_valid_i && !kill && (pred_ready_o || pop);
   assign wr_entry = '{taken: pred_taken_i, target: pred_target_i, pc: pred_pc_i};

   bp_pred_fifo #(
      .DEPTH (DEPTH),
      .T     (bp_entry_t),
      .CW    (CW)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (mispred),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (wr_entry),
      .head_o  (head),
      .count_o (count)
   );

   always_comb begin
      upd_d         = '{valid: res_hit, taken: res_hit && res_taken_i};
      flush_d       = mispred;
      redirect_d    = '0;
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      underflow_d   = underflow_q || (res_valid_i && empty);
      if (mispred) redirect_d = res_taken_i ? res_target_i : head.pc + BP_INSN_BYTES;
      if (res_hit && !(&branch_cnt_q))  branch_cnt_d  = branch_cnt_q + 1'b1;
      if (mispred && !(&mispred_cnt_q)) mispred_cnt_d = mispred_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         upd_q         <= '0;
         flush_q       <= 1'b0;
         redirect_q    <= '0;
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
         underflow_q   <= 1'b0;
      end else begin
         upd_q         <= upd_d;
         flush_q       <= flush_d;
         redirect_q    <= redirect_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
         underflow_q   <= underflow_d;
      end
   end

   assign upd_valid_o     = upd_q.valid;
   assign upd_taken_o     = upd_q.taken;
   assign flush_o         = flush_q;
   assign redirect_addr_o = redirect_q;
   assign branch_cnt_o    = branch_cnt_q;
   assign mispred_cnt_o   = mispred_cnt_q;
   assign underflow_o     = underflow_q;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Bench for branch_resolution_unit: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_branch_resolution_unit;
   import bp_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             pred_valid_i, pred_taken_i, res_valid_i, res_taken_i;
   logic [31:0]      pred_target_i, pred_pc_i, res_target_i;
   logic             pred_ready_o, upd_valid_o, upd_taken_o, flush_o, underflow_o;
   logic [31:0]      redirect_addr_o;
   logic [CNT_W-1:0] branch_cnt_o, mispred_cnt_o;

   int checks = 0;
   int errors = 0;

   branch_resolution_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .pred_valid_i    (pred_valid_i),
      .pred_taken_i    (pred_taken_i),
      .pred_target_i   (pred_target_i),
      .pred_pc_i       (pred_pc_i),
      .pred_ready_o    (pred_ready_o),
      .res_valid_i     (res_valid_i),
      .res_taken_i     (res_taken_i),
      .res_target_i    (res_target_i),
      .upd_valid_o     (upd_valid_o),
      .upd_taken_o     (upd_taken_o),
      .flush_o         (flush_o),
      .redirect_addr_o (redirect_addr_o),
      .branch_cnt_o    (branch_cnt_o),
      .mispred_cnt_o   (mispred_cnt_o),
      .underflow_o     (underflow_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: in-flight predictions as a queue, outputs as plain values.
   bp_entry_t        mq[$];
   logic             e_uv, e_ut, e_fl, e_uf;
   logic [31:0]      e_rd;
   logic [CNT_W-1:0] e_bc, e_mc;
   bit               m_hit, m_mis, m_rdy;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         e_uv = 0; e_ut = 0; e_fl = 0; e_uf = 0; e_rd = 0; e_bc = 0; e_mc = 0;
      end else begin
         m_rdy = (mq.size() != DEPTH) && !e_fl;
         m_hit = res_valid_i && (mq.size() > 0);
         m_mis = m_hit && ((res_taken_i != mq[0].taken) ||
                           (res_taken_i && res_target_i != mq[0].target));
         e_uv = m_hit;
         e_ut = m_hit && res_taken_i;
         e_rd = m_mis ? (res_taken_i ? res_target_i : mq[0].pc + 32'd4) : 32'h0;
         if (res_valid_i && mq.size() == 0) e_uf = 1;
         if (m_hit && e_bc != {CNT_W{1'b1}}) e_bc = e_bc + 1'b1;
         if (m_mis && e_mc != {CNT_W{1'b1}}) e_mc = e_mc + 1'b1;
         if (m_mis) mq.delete();
         else begin
            if (m_hit) void'(mq.pop_front());
            if (pred_valid_i && !e_fl && (m_rdy || m_hit))
               mq.push_back('{taken: pred_taken_i, target: pred_target_i, pc: pred_pc_i});
         end
         e_fl = m_mis;
      end
   end

   always @(negedge clk) begin
      chk("upd_valid", 32'(upd_valid_o), 32'(e_uv));
      chk("upd_taken", 32'(upd_taken_o), 32'(e_ut));
      chk("flush", 32'(flush_o), 32'(e_fl));
      if (e_fl) chk("redirect", redirect_addr_o, e_rd);
      chk("branch_cnt", 32'(branch_cnt_o), 32'(e_bc));
      chk("mispred_cnt", 32'(mispred_cnt_o), 32'(e_mc));
      chk("underflow", 32'(underflow_o), 32'(e_uf));
      chk("pred_ready", 32'(pred_ready_o), 32'((mq.size() != DEPTH) && !e_fl));
   end

   task automatic drive(input logic pv, input logic pt, input logic [31:0] ptg,
                        input logic [31:0] ppc, input logic rv, input logic rt,
                        input logic [31:0] rtg);
      pred_valid_i = pv; pred_taken_i = pt; pred_target_i = ptg; pred_pc_i = ppc;
      res_valid_i = rv; res_taken_i = rt; res_target_i = rtg;
      @(posedge clk);
      #2;
      pred_valid_i = 0; pred_taken_i = 0; pred_target_i = 0; pred_pc_i = 0;
      res_valid_i = 0; res_taken_i = 0; res_target_i = 0;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_upd_valid"}, 32'(upd_valid_o), 0);
      chk({tag, "_flush"}, 32'(flush_o), 0);
      chk({tag, "_redirect"}, redirect_addr_o, 0);
      chk({tag, "_branch_cnt"}, 32'(branch_cnt_o), 0);
      chk({tag, "_mispred_cnt"}, 32'(mispred_cnt_o), 0);
      chk({tag, "_underflow"}, 32'(underflow_o), 0);
      chk({tag, "_ready"}, 32'(pred_ready_o), 1);
   endtask

   initial begin
      rst_n = 0;
      pred_valid_i = 0; pred_taken_i = 0; pred_target_i = 0; pred_pc_i = 0;
      res_valid_i = 0; res_taken_i = 0; res_target_i = 0;
      #12;
      chk_zero_outputs("reset");
      rst_n = 1;
      @(posedge clk); #2;

      // Correct taken prediction
      drive(1, 1, 32'h100, 32'h80, 0, 0, 0);
      drive(0, 0, 0, 0, 1, 1, 32'h100);
      chk("t1_upd_valid", 32'(upd_valid_o), 1);
      chk("t1_upd_taken", 32'(upd_taken_o), 1);
      chk("t1_flush", 32'(flush_o), 0);
      chk("t1_branch_cnt", 32'(branch_cnt_o), 1);
      chk("t1_mispred_cnt", 32'(mispred_cnt_o), 0);

      // Predicted taken, actually not taken
      drive(1, 1, 32'h100, 32'h80, 0, 0, 0);
      drive(0, 0, 0, 0, 1, 0, 32'h0);
      chk("t2_flush", 32'(flush_o), 1);
      chk("t2_redirect", redirect_addr_o, 32'h84);
      chk("t2_upd_taken", 32'(upd_taken_o), 0);
      chk("t2_mispred_cnt", 32'(mispred_cnt_o), 1);
      idle();
      chk("t2_flush_pulse", 32'(flush_o), 0);
      chk("t2_ready", 32'(pred_ready_o), 1);

      // Wrong target, then PC wrap on not-taken redirect
      drive(1, 1, 32'h100, 32'h80, 0, 0, 0);
      drive(0, 0, 0, 0, 1, 1, 32'h200);
      chk("t3_flush", 32'(flush_o), 1);
      chk("t3_redirect", redirect_addr_o, 32'h200);
      idle();
      drive(1, 1, 32'h10, 32'hFFFF_FFFC, 0, 0, 0);
      drive(0, 0, 0, 0, 1, 0, 32'h0);
      chk("t3_wrap_flush", 32'(flush_o), 1);
      chk("t3_wrap_redirect", redirect_addr_o, 32'h0);
      idle();

      // Fill, drop a push, then push alongside a correct resolve
      for (int i = 0; i < 4; i++) drive(1, 1, 32'h2000 + 32'(i) * 32'h10, 32'h1000 + 32'(i) * 4, 0, 0, 0);
      chk("t4_full_ready", 32'(pred_ready_o), 0);
      drive(1, 1, 32'h3000, 32'h1010, 0, 0, 0);
      drive(1, 1, 32'h2040, 32'h1014, 1, 1, 32'h2000);
      chk("t4_flush", 32'(flush_o), 0);
      chk("t4_ready_still_full", 32'(pred_ready_o), 0);
      drive(0, 0, 0, 0, 1, 0, 32'h0);
      chk("t4_head2_flush", 32'(flush_o), 1);
      chk("t4_head2_redirect", redirect_addr_o, 32'h1008);
      idle();

      // Flush squashes pushes in N and N+1, then an empty resolve underflows
      for (int i = 0; i < 3; i++) drive(1, 1, 32'h4000, 32'h500 + 32'(i) * 4, 0, 0, 0);
      drive(1, 1, 32'h4000, 32'h600, 1, 0, 32'h0);
      chk("t5_flush", 32'(flush_o), 1);
      chk("t5_ready_n1", 32'(pred_ready_o), 0);
      drive(1, 1, 32'h4000, 32'h604, 0, 0, 0);
      chk("t5_ready_n2", 32'(pred_ready_o), 1);
      drive(0, 0, 0, 0, 1, 1, 32'h4000);
      chk("t6_upd_valid", 32'(upd_valid_o), 0);
      chk("t6_underflow", 32'(underflow_o), 1);
      idle();
      chk("t6_underflow_sticky", 32'(underflow_o), 1);

      // Randomised traffic with an asynchronous reset in the middle
      for (int n = 0; n < 1600; n++) begin
         logic        pv, pt, rv, rt;
         logic [31:0] ptg, ppc, rtg;
         if (n == 800) begin
            @(posedge clk); #4;
            rst_n = 0;
            #1;
            chk_zero_outputs("async_rst");
            @(posedge clk); #3;
            rst_n = 1;
            #4;
         end
         pv  = 1'($urandom % 2);
         pt  = 1'($urandom % 2);
         ptg = 32'($urandom_range(0, 3)) * 32'h40;
         ppc = 32'($urandom) & 32'hFFFF_FFFC;
         rv  = (mq.size() > 0) ? ($urandom % 3 != 0) : ($urandom % 20 == 0);
         rt  = 1'($urandom % 2);
         rtg = (mq.size() > 0 && $urandom % 4 != 0) ? mq[0].target
                                                   : 32'($urandom_range(0, 3)) * 32'h40;
         drive(pv, pt, ptg, ppc, rv, rt, rtg);
      end
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
